// File: rtl/kv_fpu_pkg.sv
// Shared FPU definitions: SEW one-hot encoding, fflags field layout and the
// integer-writeback queue entry.
package kv_fpu_pkg;

  // One-hot SEW bit positions as presented on the FPU result bus.
  localparam int unsigned SEW64_BIT = 2;
  localparam int unsigned SEW32_BIT = 1;
  localparam int unsigned SEW16_BIT = 0;

  // fflags layout {NV,DZ,OF,UF,NX}.
  localparam int unsigned FFLAGS_W  = 5;
  localparam int unsigned FFLAGS_NX = 0;
  localparam int unsigned FFLAGS_UF = 1;
  localparam int unsigned FFLAGS_OF = 2;
  localparam int unsigned FFLAGS_DZ = 3;
  localparam int unsigned FFLAGS_NV = 4;

  // Entries are always carried at full 64-bit width; narrower XLEN
  // builds drop the upper half at the output.
  localparam int unsigned XWB_RD_W   = 5;
  localparam int unsigned XWB_DATA_W = 64;

  typedef struct packed {
    logic [XWB_RD_W-1:0]   rd;
    logic [XWB_DATA_W-1:0] data;
    logic [FFLAGS_W-1:0]   flags;
  } xwb_entry_t;

  function automatic logic sew_is_onehot(input logic [2:0] sew);
    return $onehot(sew);
  endfunction

endpackage

// File: rtl/kv_sync_fifo.sv
// Synchronous FIFO with valid/ready on both sides and a single-cycle flush.
// Head data reads as zero while empty; storage itself is never reset.
module kv_sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [Width-1:0] out_data
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;

  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW:0]    count_q, count_d;
  logic [Width-1:0] mem_q [Depth];
  logic             full;
  logic             push;
  logic             pop;

  assign full      = (count_q == (PtrW+1)'(Depth));
  assign in_ready  = ~full;
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready & ~flush;
  assign pop       = out_valid & out_ready & ~flush;
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : '0;

  // Depth is a power of two, so pointers wrap by plain overflow.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + (PtrW+1)'(1);
        2'b01:   count_d = count_q - (PtrW+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= in_data;
  end

endmodule

// File: rtl/kv_fpu_xwb_queue.sv
// FP-to-integer writeback return queue: formats FPU results per SEW into
// XLEN and buffers them for the integer writeback arbiter.
module kv_fpu_xwb_queue
  import kv_fpu_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned DEPTH = 2,
  parameter int unsigned RD_W  = 5
) (
  input  logic            core_clk,
  input  logic            core_reset_n,
  input  logic            xwb_in_valid,
  output logic            xwb_in_ready,
  input  logic [RD_W-1:0] xwb_in_rd,
  input  logic [2:0]      xwb_in_sew,
  input  logic            xwb_in_raw,
  input  logic [63:0]     xwb_in_data,
  input  logic [4:0]      xwb_in_flags,
  input  logic            flush,
  output logic            iwb_valid,
  input  logic            iwb_ready,
  output logic [RD_W-1:0] iwb_rd,
  output logic [XLEN-1:0] iwb_data,
  output logic [4:0]      iwb_flags,
  output logic            xwb_sew_err,
  output logic            xwb_standby_ready
);

  xwb_entry_t in_entry;
  xwb_entry_t head;
  logic [63:0] fmt_data;
  logic        sew_bad;
  logic        push;
  logic        sew_err_q;

  assign sew_bad = ~xwb_in_raw & ~sew_is_onehot(xwb_in_sew);
  assign push    = xwb_in_valid & xwb_in_ready & ~flush;

  // Sign-extend at 64 bits; narrower XLEN takes the low slice at the output.
  always_comb begin
    fmt_data = '0;
    if (xwb_in_raw) begin
      fmt_data = xwb_in_data;
    end else if (!sew_bad) begin
      if (xwb_in_sew[SEW64_BIT]) begin
        fmt_data = xwb_in_data;
      end else if (xwb_in_sew[SEW32_BIT]) begin
        fmt_data = {{32{xwb_in_data[31]}}, xwb_in_data[31:0]};
      end else if (xwb_in_sew[SEW16_BIT]) begin
        fmt_data = {{48{xwb_in_data[15]}}, xwb_in_data[15:0]};
      end
    end
  end

  always_comb begin
    in_entry       = '0;
    in_entry.rd    = XWB_RD_W'(xwb_in_rd);
    in_entry.data  = fmt_data;
    in_entry.flags = xwb_in_flags;
  end

  kv_sync_fifo #(
    .Width ($bits(xwb_entry_t)),
    .Depth (DEPTH)
  ) u_fifo (
    .clk       (core_clk),
    .rst_n     (core_reset_n),
    .flush     (flush),
    .in_valid  (xwb_in_valid),
    .in_ready  (xwb_in_ready),
    .in_data   (in_entry),
    .out_valid (iwb_valid),
    .out_ready (iwb_ready),
    .out_data  (head)
  );

  assign iwb_rd    = RD_W'(head.rd);
  assign iwb_data  = head.data[XLEN-1:0];
  assign iwb_flags = head.flags;

  // A bad SEW still queues a zeroed entry so the writeback is not lost.
  always_ff @(posedge core_clk or negedge core_reset_n) begin
    if (!core_reset_n) begin
      sew_err_q <= 1'b0;
    end else begin
      sew_err_q <= push & sew_bad;
    end
  end

  assign xwb_sew_err       = sew_err_q;
  assign xwb_standby_ready = ~iwb_valid & ~xwb_in_valid;

  if (XLEN < 64) begin : g_trunc_chk
    sew64_on_narrow_xlen : assert property (@(posedge core_clk) disable iff (!core_reset_n)
      !(push && !xwb_in_raw && xwb_in_sew == 3'b100))
      else $error("sew64 result truncated to XLEN");
  end

endmodule

// File: tb/tb_kv_fpu_xwb_queue.sv
// Bench for kv_fpu_xwb_queue: directed vector table, hand sequences for
// stall/flush/reset, and randomized traffic against a queue-based model.
module tb_kv_fpu_xwb_queue;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned RD_W  = 5;

  logic            core_clk = 1'b0;
  logic            core_reset_n;
  logic            xwb_in_valid;
  logic            xwb_in_ready;
  logic [RD_W-1:0] xwb_in_rd;
  logic [2:0]      xwb_in_sew;
  logic            xwb_in_raw;
  logic [63:0]     xwb_in_data;
  logic [4:0]      xwb_in_flags;
  logic            flush;
  logic            iwb_valid;
  logic            iwb_ready;
  logic [RD_W-1:0] iwb_rd;
  logic [XLEN-1:0] iwb_data;
  logic [4:0]      iwb_flags;
  logic            xwb_sew_err;
  logic            xwb_standby_ready;

  always #5 core_clk = ~core_clk;

  kv_fpu_xwb_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH),
    .RD_W  (RD_W)
  ) dut (
    .core_clk          (core_clk),
    .core_reset_n      (core_reset_n),
    .xwb_in_valid      (xwb_in_valid),
    .xwb_in_ready      (xwb_in_ready),
    .xwb_in_rd         (xwb_in_rd),
    .xwb_in_sew        (xwb_in_sew),
    .xwb_in_raw        (xwb_in_raw),
    .xwb_in_data       (xwb_in_data),
    .xwb_in_flags      (xwb_in_flags),
    .flush             (flush),
    .iwb_valid         (iwb_valid),
    .iwb_ready         (iwb_ready),
    .iwb_rd            (iwb_rd),
    .iwb_data          (iwb_data),
    .iwb_flags         (iwb_flags),
    .xwb_sew_err       (xwb_sew_err),
    .xwb_standby_ready (xwb_standby_ready)
  );

  typedef struct {
    logic [RD_W-1:0] rd;
    logic [63:0]     data;
    logic [4:0]      flags;
  } ent_t;

  typedef struct {
    logic        v;
    logic [4:0]  rd;
    logic [2:0]  sew;
    logic        raw;
    logic [63:0] data;
    logic [4:0]  flags;
    logic        rdy;
    logic        e_v;
    logic [63:0] e_d;
    logic [4:0]  e_f;
    logic        e_rdy;
    logic        e_err;
  } vec_t;

  ent_t model_q[$];
  bit   model_err;
  int   vectors     = 0;
  int   miscompares = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sign extension via arithmetic: a negative value is its unsigned value minus 2^w.
  function automatic logic [63:0] ref_fmt(input logic [2:0] sew, input logic raw,
                                          input logic [63:0] d);
    logic [63:0] r;
    if (raw) return d;
    case (sew)
      3'b100: return d;
      3'b010: begin
        r = {32'h0, d[31:0]};
        if (d[31]) r = r - 64'h1_0000_0000;
        return r;
      end
      3'b001: begin
        r = {48'h0, d[15:0]};
        if (d[15]) r = r - 64'h1_0000;
        return r;
      end
      default: return 64'h0;
    endcase
  endfunction

  task automatic check_model();
    bit nonempty;
    nonempty = (model_q.size() != 0);
    chk("iwb_valid", iwb_valid, nonempty);
    chk("xwb_in_ready", xwb_in_ready, model_q.size() < DEPTH);
    chk("xwb_sew_err", xwb_sew_err, model_err);
    chk("xwb_standby_ready", xwb_standby_ready, !nonempty && !xwb_in_valid);
    if (nonempty) begin
      chk("iwb_rd", iwb_rd, model_q[0].rd);
      chk("iwb_data", iwb_data, model_q[0].data);
      chk("iwb_flags", iwb_flags, model_q[0].flags);
    end else begin
      chk("iwb_data_empty", iwb_data, 64'h0);
    end
  endtask

  task automatic update_model();
    bit   push;
    bit   pop;
    ent_t e;
    push = xwb_in_valid && (model_q.size() < DEPTH) && !flush;
    pop  = (model_q.size() != 0) && iwb_ready && !flush;
    model_err = push && !xwb_in_raw && !$onehot(xwb_in_sew);
    if (flush) begin
      model_q.delete();
    end else begin
      if (pop) void'(model_q.pop_front());
      if (push) begin
        e.rd    = xwb_in_rd;
        e.data  = ref_fmt(xwb_in_sew, xwb_in_raw, xwb_in_data);
        e.flags = xwb_in_flags;
        model_q.push_back(e);
      end
    end
  endtask

  // Inputs are set before calling; checks at negedge, model steps with the posedge.
  task automatic run_cycle();
    @(negedge core_clk);
    check_model();
    @(posedge core_clk);
    update_model();
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] rd, input logic [2:0] sew,
                       input logic raw, input logic [63:0] d, input logic [4:0] f,
                       input logic fl, input logic rdy);
    xwb_in_valid = v;
    xwb_in_rd    = rd;
    xwb_in_sew   = sew;
    xwb_in_raw   = raw;
    xwb_in_data  = d;
    xwb_in_flags = f;
    flush        = fl;
    iwb_ready    = rdy;
  endtask

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{1, 5'd1, 3'b010, 0, 64'h0000_0000_8000_0001, 5'b00001, 1,
                0, 64'h0, 5'b0, 1, 0};
    tbl[1]  = '{0, 5'd0, 3'b000, 0, 64'h0, 5'b0, 1,
                1, 64'hFFFF_FFFF_8000_0001, 5'b00001, 1, 0};
    tbl[2]  = '{0, 5'd0, 3'b000, 0, 64'h0, 5'b0, 1,
                0, 64'h0, 5'b0, 1, 0};
    tbl[3]  = '{1, 5'd2, 3'b001, 0, 64'h1234_5678_0000_7FFF, 5'b0, 0,
                0, 64'h0, 5'b0, 1, 0};
    tbl[4]  = '{1, 5'd3, 3'b000, 1, 64'h1, 5'b00010, 0,
                1, 64'h7FFF, 5'b0, 1, 0};
    tbl[5]  = '{0, 5'd0, 3'b000, 0, 64'h0, 5'b0, 1,
                1, 64'h7FFF, 5'b0, 0, 0};
    tbl[6]  = '{0, 5'd0, 3'b000, 0, 64'h0, 5'b0, 1,
                1, 64'h1, 5'b00010, 1, 0};
    tbl[7]  = '{0, 5'd0, 3'b000, 0, 64'h0, 5'b0, 1,
                0, 64'h0, 5'b0, 1, 0};
    tbl[8]  = '{1, 5'd4, 3'b011, 0, 64'hFFFF, 5'b10000, 0,
                0, 64'h0, 5'b0, 1, 0};
    tbl[9]  = '{0, 5'd0, 3'b000, 0, 64'h0, 5'b0, 1,
                1, 64'h0, 5'b10000, 1, 1};
    tbl[10] = '{0, 5'd0, 3'b000, 0, 64'h0, 5'b0, 1,
                0, 64'h0, 5'b0, 1, 0};

    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_err    = 0;
    core_reset_n = 1'b0;
    repeat (2) @(posedge core_clk);
    #1;
    chk("reset_iwb_valid", iwb_valid, 1'b0);
    chk("reset_in_ready", xwb_in_ready, 1'b1);
    chk("reset_sew_err", xwb_sew_err, 1'b0);
    chk("reset_standby", xwb_standby_ready, 1'b1);
    chk("reset_iwb_data", iwb_data, 64'h0);
    @(negedge core_clk);
    core_reset_n = 1'b1;
    @(posedge core_clk);
    #1;

    // Directed vector table: sew32, sew16 + raw ordering, bad SEW.
    for (int i = 0; i < 11; i++) begin
      drive(tbl[i].v, tbl[i].rd, tbl[i].sew, tbl[i].raw, tbl[i].data, tbl[i].flags,
            1'b0, tbl[i].rdy);
      @(negedge core_clk);
      check_model();
      chk($sformatf("tbl%0d_valid", i), iwb_valid, tbl[i].e_v);
      chk($sformatf("tbl%0d_data", i), iwb_data, tbl[i].e_d);
      chk($sformatf("tbl%0d_flags", i), iwb_flags, tbl[i].e_f);
      chk($sformatf("tbl%0d_ready", i), xwb_in_ready, tbl[i].e_rdy);
      chk($sformatf("tbl%0d_sew_err", i), xwb_sew_err, tbl[i].e_err);
      @(posedge core_clk);
      update_model();
      #1;
    end

    // Stall with three back-to-back pushes into a two-deep queue.
    drive(1, 5'd5, 3'b100, 0, 64'hAAAA_0000_0000_0001, 5'd1, 0, 0); run_cycle();
    drive(1, 5'd6, 3'b100, 0, 64'hBBBB_0000_0000_0002, 5'd2, 0, 0); run_cycle();
    chk("stall_ready_drop", xwb_in_ready, 1'b0);
    drive(1, 5'd7, 3'b100, 0, 64'hCCCC_0000_0000_0003, 5'd3, 0, 0); run_cycle();
    chk("stall_head_stable", iwb_data, 64'hAAAA_0000_0000_0001);
    iwb_ready = 1'b1; run_cycle();
    chk("stall_ready_back", xwb_in_ready, 1'b1);
    chk("stall_second", iwb_data, 64'hBBBB_0000_0000_0002);
    run_cycle();
    xwb_in_valid = 1'b0;
    repeat (3) run_cycle();

    // Full queue, push coincident with flush.
    drive(1, 5'd8, 3'b010, 0, 64'h1111, 5'd0, 0, 0); run_cycle();
    drive(1, 5'd9, 3'b010, 0, 64'h2222, 5'd0, 0, 0); run_cycle();
    drive(1, 5'd10, 3'b010, 0, 64'h3333, 5'd0, 1, 1); run_cycle();
    chk("flush_valid", iwb_valid, 1'b0);
    chk("flush_ready", xwb_in_ready, 1'b1);
    drive(0, 0, 0, 0, 0, 0, 0, 1);
    repeat (3) run_cycle();

    // Asynchronous reset with two entries queued.
    drive(1, 5'd11, 3'b001, 0, 64'h8000, 5'd4, 0, 0); run_cycle();
    drive(1, 5'd12, 3'b001, 0, 64'h0001, 5'd5, 0, 0); run_cycle();
    xwb_in_valid = 1'b0;
    #2 core_reset_n = 1'b0;
    #1;
    chk("async_reset_valid", iwb_valid, 1'b0);
    model_q.delete();
    model_err = 0;
    @(negedge core_clk);
    core_reset_n = 1'b1;
    #1;
    chk("post_reset_ready", xwb_in_ready, 1'b1);
    chk("post_reset_standby", xwb_standby_ready, 1'b1);
    run_cycle();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      logic [2:0] sew;
      int unsigned pick;
      pick = $urandom_range(0, 9);
      if (pick == 0) sew = 3'($urandom_range(0, 7));
      else if (pick < 4) sew = 3'b001;
      else if (pick < 7) sew = 3'b010;
      else sew = 3'b100;
      drive($urandom_range(0, 9) < 6, 5'($urandom), sew, $urandom_range(0, 4) == 0,
            {$urandom, $urandom}, 5'($urandom), $urandom_range(0, 19) == 0,
            $urandom_range(0, 1) == 1);
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/kv_fpu_xwb_queue.md
Name: kv_fpu_xwb_queue

Overview:
- Return-path queue for FPU results bound for the integer register file: fmv.x, fcmp, fclass, and fcvt-to-int.
- Receives the raw 64-bit FPU result with its element width, sign-extends per SEW to XLEN, and buffers it in a small FIFO.
- Drains to the integer writeback port through a valid/ready handshake.
- Sits between the FPU F1/F2 result mux and the integer pipeline's writeback arbiter. It is the consuming end of the FP-to-integer move path.

Parameters:
- XLEN, 64, integer register width; legal values 32 or 64.
- DEPTH, 2, number of FIFO entries; must be at least 2 and a power of two.
- RD_W, 5, destination register index width.

Ports:
- core_clk  input  1  core clock.
- core_reset_n  input  1  asynchronous active-low reset.
- xwb_in_valid  input  1  FPU presents a result.
- xwb_in_ready  output  1  queue can accept; equals ~full.
- xwb_in_rd  input  RD_W  destination integer register.
- xwb_in_sew  input  3  one-hot element width {64,32,16} on bits [2:0].
- xwb_in_raw  input  1  result is already XLEN-formatted (fcmp/fclass); SEW is ignored.
- xwb_in_data  input  64  FPU result; lower bits are significant per SEW.
- xwb_in_flags  input  5  fflags {NV,DZ,OF,UF,NX} produced with the result.
- flush  input  1  kill all queued entries.
- iwb_valid  output  1  head entry available.
- iwb_ready  input  1  integer writeback accepts.
- iwb_rd  output  RD_W  head destination register.
- iwb_data  output  XLEN  head formatted data.
- iwb_flags  output  5  head fflags.
- xwb_sew_err  output  1  one-cycle pulse when a non-raw push has a SEW that is not one-hot.
- xwb_standby_ready  output  1  queue empty and no xwb_in_valid; permits clock gating.

Behaviour:
- Reset (core_reset_n low, asynchronous):
  - count, rd_ptr, wr_ptr and the sew_err flop clear to 0.
  - Storage is not reset.
  - Resulting outputs: iwb_valid=0, iwb_rd/iwb_data/iwb_flags=0 (masked by iwb_valid), xwb_in_ready=1, xwb_sew_err=0, xwb_standby_ready=~xwb_in_valid.
- Push: occurs when xwb_in_valid & xwb_in_ready & ~flush. The formatted entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Formatting (applied at push, combinational):
  - raw=1: data[XLEN-1:0].
  - sew64: data[XLEN-1:0]. With XLEN=32 this truncates, and an assertion fires.
  - sew32: {{(XLEN-32){data[31]}}, data[31:0]}.
  - sew16: {{(XLEN-16){data[15]}}, data[15:0]}.
  - Non-one-hot SEW with raw=0: data written as 0, flags passed unchanged, xwb_sew_err pulses the next cycle. The entry is still queued, so the writeback is not lost.
- Pop: occurs when iwb_valid & iwb_ready & ~flush, and rd_ptr increments modulo DEPTH.
- iwb_valid = (count != 0). The head outputs are driven from storage[rd_ptr] and are zero when empty.
- Latency: a push at cycle N is visible at iwb_valid in cycle N+1. There is no combinational bypass from input to output.
- Count: increments on push-only, decrements on pop-only, unchanged on simultaneous push and pop.
  - Full with simultaneous pop: xwb_in_ready is still 0 that cycle (ready = ~full, no pop-through), and becomes 1 in the next cycle.
  - Empty: a pop cannot occur. iwb_ready is ignored.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. Count is log2(DEPTH)+1 bits.
- Flush:
  - Has priority over push and pop in the same cycle.
  - Pointers and count clear at the next edge, so iwb_valid=0 from the following cycle.
  - Any push in the flush cycle is discarded, and no handshake is credited.
  - A pending sew_err pulse from the prior cycle still asserts.
- Handshake rules:
  - iwb_rd/data/flags stay stable while iwb_valid & ~iwb_ready.
  - iwb_valid never drops without a pop or a flush.
- Reset asserted mid-transfer: the queue empties immediately (asynchronously), and queued results are lost by definition.

Decomposition:
- Shared package kv_fpu_pkg holds:
  - SEW one-hot bit positions (SEW64_BIT=2, SEW32_BIT=1, SEW16_BIT=0).
  - FFLAGS field indices.
  - The entry struct {rd, data, flags}.
- The formatting logic stays inline.
- Sub-module kv_sync_fifo (parameterised width/depth, valid/ready, flush) holds storage and pointers. kv_fpu_xwb_queue wraps it with the formatting and SEW checking.

Test Plan:
1. sew32 push, data=0x0000_0000_8000_0001, iwb_ready=1 -> the next cycle iwb_valid=1, iwb_data=0xFFFF_FFFF_8000_0001; popped the same cycle, queue empty after.
2. sew16 push, data=0x1234_5678_0000_7FFF, then a raw push with data=0x1 -> two pops in order: 0x0000_0000_0000_7FFF, then 0x0000_0000_0000_0001.
3. iwb_ready=0 with 3 back-to-back pushes (DEPTH=2) -> xwb_in_ready drops after the 2nd push; the 3rd is held. Releasing iwb_ready: the pop-only cycle re-asserts ready the next cycle, then the 3rd is accepted. Order is preserved and outputs stay stable while stalled.
4. Full queue with push and flush in the same cycle -> next cycle iwb_valid=0, count=0, xwb_in_ready=1; the flushed push never appears.
5. Non-raw push with sew=3'b011, data=0xFFFF, flags=5'b10000 -> xwb_sew_err pulses 1 cycle; entry popped with iwb_data=0 and iwb_flags=5'b10000.
6. core_reset_n asserted with 2 entries queued -> iwb_valid=0 immediately; after release, xwb_in_ready=1 and xwb_standby_ready=1 with no input valid.
